series_batch_sequencer: RTL and testbench

Upstream feeder for the ROM-coefficient series unit, which computes a result by multiply/accumulate over ROM terms.
- Buffers operand words x from a valid/ready producer in a small FIFO.
- Issues one-cycle start pulses to the series unit and tracks its ready level to detect completion.
- Captures each result into a valid/ready output register, so batches of x run back-to-back without software pacing.

---
 rtl/series_seq_pkg.sv | 17 +
 rtl/series_seq_fifo.sv | 65 ++++++
 rtl/series_batch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_series_batch_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/series_seq_pkg.sv
// Shared types and default widths for the series batch sequencer and its FIFO.
package series_seq_pkg;

  localparam int STATE_W     = 2;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RES_W   = 16;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/series_seq_fifo.sv
// First-word-fall-through operand FIFO; the head entry is visible on rdata whenever the FIFO is not empty.
module series_seq_fifo
  import series_seq_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  // Overflow/underflow requests are ignored so the pointers can never be corrupted.
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;
  assign rdata = mem_r[rd_ptr_r];

  // Storage array: written on push only, no reset needed since count gates visibility.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/series_batch_sequencer.sv
// Feeds buffered operands to the series unit one start pulse at a time and holds each result for the consumer.
// Optional watchdog with sticky timeout_err port: define SEQ_WATCHDOG_EN.
module series_batch_sequencer
  import series_seq_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int RES_W          = DEF_RES_W,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   core_start,
  output logic [DATA_W-1:0]      core_x,
  input  logic                   core_ready,
  input  logic [RES_W-1:0]       core_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RES_W-1:0]       out_data,
  output logic                   busy,
`ifdef SEQ_WATCHDOG_EN
  output logic                   timeout_err,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  seq_state_e        state_r;
  seq_state_e        state_s;
  logic              push_s;
  logic              pop_s;
  logic              capture_s;
  logic              wd_hit_s;
  logic [DATA_W-1:0] head_s;
  logic [CNT_W-1:0]  count_s;
  logic              full_s;
  logic              empty_s;
  logic              core_start_r;
  logic [DATA_W-1:0] core_x_r;
  logic              out_valid_r;
  logic [RES_W-1:0]  out_data_r;
  logic              busy_r;

  // in_ready is held low during reset and never looks at a same-cycle pop.
  assign in_ready = ~reset & ~full_s;
  assign push_s   = in_valid & in_ready;

  series_seq_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (in_data),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WD_W-1:0] wd_r;
  logic            timeout_err_r;

  assign wd_hit_s    = (wd_r == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_r;

  // Watchdog: restarts on each issue, counts while waiting on the series unit; error flag is sticky.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_r          <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      if (state_s == ISSUE) begin
        wd_r <= '0;
      end else if (((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) && !wd_hit_s) begin
        wd_r <= wd_r + 1'b1;
      end
      if (((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) && wd_hit_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end
`else
  assign wd_hit_s = 1'b0;
`endif

  // Next-state decode; a watchdog expiry wins over a same-cycle completion and drops the operand.
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && core_ready && !out_valid_r) begin
          state_s = ISSUE;
          pop_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (wd_hit_s) begin
          state_s = IDLE;
        end else if (!core_ready) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (wd_hit_s) begin
          state_s = IDLE;
        end else if (core_ready) begin
          state_s   = IDLE;
          capture_s = 1'b1;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; core_start and busy are decoded from the next state so they align with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      core_start_r <= 1'b0;
      core_x_r     <= '0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      core_start_r <= (state_s == ISSUE);
      busy_r       <= (state_s != IDLE);
      if (pop_s) begin
        core_x_r <= head_s;
      end
      if (capture_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= core_result;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign core_start = core_start_r;
  assign core_x     = core_x_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign busy       = busy_r;
  assign fifo_count = count_s;

endmodule

// File: tb/tb_series_batch_sequencer.sv
// Directed bench for series_batch_sequencer with a small behavioural series unit (result = 3*x + 0x100, 3-cycle busy).
module tb_series_batch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        core_start;
  logic [15:0] core_x;
  logic        core_ready;
  logic [15:0] core_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;
  logic [2:0]  fifo_count;
`ifdef SEQ_WATCHDOG_EN
  logic        timeout_err;
`endif

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int double_start = 0;
  logic prev_start = 1'b0;
  logic [15:0] res_q [$];

  logic        m_ready;
  logic [15:0] m_x;
  logic [15:0] m_res;
  logic [1:0]  m_cnt;
  logic        stall = 1'b0;

  logic [15:0] exp_res [10] = '{16'h0109, 16'h0103, 16'h0106, 16'h0109, 16'h010C,
                                16'h010F, 16'h0112, 16'h0115, 16'h0118, 16'h011B};

  always #5 clock = ~clock;

  series_batch_sequencer #(
    .DATA_W(16), .RES_W(16), .DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .core_start  (core_start),
    .core_x      (core_x),
    .core_ready  (core_ready),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
`ifdef SEQ_WATCHDOG_EN
    .timeout_err (timeout_err),
`endif
    .fifo_count  (fifo_count)
  );

  assign core_ready  = m_ready;
  assign core_result = m_res;

  // Series unit model: drops ready after sampling start, returns it 3 edges later unless stalled.
  always @(posedge clock) begin
    if (reset) begin
      m_ready <= 1'b1;
      m_cnt   <= 2'd0;
      m_x     <= 16'h0000;
      m_res   <= 16'h0000;
    end else if (m_ready && core_start) begin
      m_ready <= 1'b0;
      m_cnt   <= 2'd3;
      m_x     <= core_x;
    end else if (!m_ready && !stall) begin
      if (m_cnt <= 2'd1) begin
        m_ready <= 1'b1;
        m_cnt   <= 2'd0;
        m_res   <= m_x * 16'd3 + 16'h0100;
      end else begin
        m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  // Monitor: start pulses, back-to-back starts and accepted results.
  always @(posedge clock) begin
    if (!reset && core_start) start_cnt <= start_cnt + 1;
    if (core_start && prev_start) double_start <= double_start + 1;
    prev_start <= core_start;
    if (!reset && out_valid && out_ready) res_q.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (out_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_results(input string tag, input int num, input int max);
    int n = 0;
    while (res_q.size() < num && n < max) begin
      tick();
      n++;
    end
    check(tag, res_q.size(), num);
  endtask

  initial begin
    int n;
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single operand, result left unconsumed
    in_valid = 1'b1; in_data = 16'h0003;
    tick();
    in_valid = 1'b0;
    check("single_count", {29'd0, fifo_count}, 32'd1);
    check("single_no_start_yet", {31'd0, core_start}, 32'd0);
    tick();
    check("single_start", {31'd0, core_start}, 32'd1);
    check("single_core_x", {16'd0, core_x}, 32'h0003);
    check("single_busy", {31'd0, busy}, 32'd1);
    check("single_popped", {29'd0, fifo_count}, 32'd0);
    tick();
    check("single_start_1cyc", {31'd0, core_start}, 32'd0);
    wait_valid("single_wait", 20);
    check("single_result", {16'd0, out_data}, 32'h0109);

    // Fill the FIFO while blocked by the pending result
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
    end
    check("fill_count", {29'd0, fifo_count}, 32'd4);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    in_data = 16'h0005;
    tick(); tick(); tick();
    check("held_count", {29'd0, fifo_count}, 32'd4);
    check("held_no_issue", start_cnt, 32'd1);
    check("held_out_valid", {31'd0, out_valid}, 32'd1);
    check("held_out_data", {16'd0, out_data}, 32'h0109);
    out_ready = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_start", {31'd0, core_start}, 32'd1);
    check("release_core_x", {16'd0, core_x}, 32'h0001);
    tick();
    in_valid = 1'b0;
    check("fifth_pushed", {29'd0, fifo_count}, 32'd4);
    wait_results("stream_count", 6, 200);

    // Simultaneous push and pop at count 2
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0006;
    tick();
    in_valid = 1'b0;
    wait_valid("six_wait", 30);
    check("six_result", {16'd0, out_data}, 32'h0112);
    in_valid = 1'b1; in_data = 16'h0007;
    tick();
    in_data = 16'h0008;
    tick();
    in_valid = 1'b0;
    check("two_buffered", {29'd0, fifo_count}, 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0009;
    tick();
    in_valid = 1'b0;
    check("pushpop_count", {29'd0, fifo_count}, 32'd2);
    check("pushpop_start", {31'd0, core_start}, 32'd1);
    check("pushpop_core_x", {16'd0, core_x}, 32'h0007);
    out_ready = 1'b1;
    wait_results("wrap_count", 10, 200);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("order_%0d", i), (i < res_q.size()) ? {16'd0, res_q[i]} : 32'hDEAD, {16'd0, exp_res[i]});
    end
    out_ready = 1'b0;

    // Reset while waiting on the core with two operands buffered
    stall = 1'b1;
    in_valid = 1'b1; in_data = 16'h000A;
    tick();
    in_data = 16'h000B;
    tick();
    in_data = 16'h000C;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("midop_busy", {31'd0, busy}, 32'd1);
    check("midop_count", {29'd0, fifo_count}, 32'd2);
    reset = 1'b1;
    tick();
    check("midrst_count", {29'd0, fifo_count}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_core_start", {31'd0, core_start}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("no_stale_valid", {31'd0, out_valid}, 32'd0);
    check("no_stale_results", res_q.size(), 32'd10);
    check("start_total", start_cnt, 32'd11);

`ifdef SEQ_WATCHDOG_EN
    stall = 1'b1;
    in_valid = 1'b1; in_data = 16'h000D;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("wd_err", {31'd0, timeout_err}, 32'd1);
    check("wd_idle", {31'd0, busy}, 32'd0);
    check("wd_no_valid", {31'd0, out_valid}, 32'd0);
    stall = 1'b0;
    in_valid = 1'b1; in_data = 16'h000E;
    tick();
    in_valid = 1'b0;
    wait_valid("wd_next_wait", 40);
    check("wd_next_result", {16'd0, out_data}, 32'h012A);
    check("wd_sticky", {31'd0, timeout_err}, 32'd1);
    check("wd_start_total", start_cnt, 32'd13);
`endif

    check("no_double_start", double_start, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
